// File: rtl/el2_soc_pkg.sv
// el2_soc_pkg: register word offsets, CTRL bit positions and AHB transfer encodings
package el2_soc_pkg;
    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_RELOAD = 3'd1;
    localparam logic [2:0] A_VALUE  = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_MODE   = 3'd4;
    localparam logic [2:0] A_PEND   = 3'd5;
    localparam logic [2:0] A_MASK   = 3'd6;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_TICKINT = 1;
    localparam int CTRL_AUTO    = 2;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
endpackage

// File: rtl/el2_irq_sync_edge.sv
// el2_irq_sync_edge: one IRQ channel - synchroniser, rise detect and level/edge pending latch
module el2_irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_irq,
    input  logic i_edge,
    input  logic i_w1c,
    output logic o_pend,
    output logic o_pend_nxt
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_rise;

    assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign o_pend_nxt = i_edge ? (w_rise | (o_pend & ~i_w1c)) : r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            o_pend <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_hist <= r_sync[SYNC_STAGES-1];
            o_pend <= o_pend_nxt;
        end
    end
endmodule

// File: rtl/el2_soc_irq_systick.sv
// el2_soc_irq_systick: AHB-Lite register slave with SysTick timer and conditioned external IRQs
module el2_soc_irq_systick
    import el2_soc_pkg::*;
#(
    parameter int NUM_IRQ     = 15,
    parameter int DIV_W       = 24,
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic               HREADYOUT,
    output logic [31:0]        HRDATA,
    output logic               HRESP,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic [DIV_W-1:0]   SYSTICKCLKDIV,
    output logic               timer_int,
    output logic [NUM_IRQ-1:0] extintsrc_req
);
    logic               r_wr;
    logic [2:0]         r_addr;
    logic [2:0]         r_ctrl, w_ctrl_nxt;
    logic [CNT_W-1:0]   r_reload, w_reload_nxt, r_value, w_value_nxt;
    logic [DIV_W-1:0]   r_presc, w_presc_nxt;
    logic               r_flag, w_flag_nxt, r_expired, w_expired_nxt;
    logic [NUM_IRQ-1:0] r_mode, w_mode_nxt, r_mask, w_mask_nxt;
    logic [NUM_IRQ-1:0] w_pend, w_pend_nxt, w_pend_w1c;
    logic               w_sel, w_tick, w_zero, w_set;
    logic               w_wr_ctrl, w_wr_reload, w_wr_value, w_wr_status, w_wr_mode, w_wr_pend, w_wr_mask;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign w_unused  = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA};

    assign w_sel       = HSEL & HREADY & (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign w_wr_ctrl   = r_wr && r_addr == A_CTRL;
    assign w_wr_reload = r_wr && r_addr == A_RELOAD;
    assign w_wr_value  = r_wr && r_addr == A_VALUE;
    assign w_wr_status = r_wr && r_addr == A_STATUS;
    assign w_wr_mode   = r_wr && r_addr == A_MODE;
    assign w_wr_pend   = r_wr && r_addr == A_PEND;
    assign w_wr_mask   = r_wr && r_addr == A_MASK;

    assign w_tick = r_ctrl[CTRL_EN] && r_presc == SYSTICKCLKDIV;
    assign w_zero = r_value == '0;
    // One-shot mode flags only once at zero until VALUE is rewritten
    assign w_set  = w_tick & ~w_wr_value & w_zero & (r_ctrl[CTRL_AUTO] | ~r_expired);

    assign w_ctrl_nxt    = w_wr_ctrl ? HWDATA[2:0] : r_ctrl;
    assign w_reload_nxt  = w_wr_reload ? HWDATA[CNT_W-1:0] : r_reload;
    assign w_mode_nxt    = w_wr_mode ? HWDATA[NUM_IRQ-1:0] : r_mode;
    assign w_mask_nxt    = w_wr_mask ? HWDATA[NUM_IRQ-1:0] : r_mask;
    assign w_presc_nxt   = (!r_ctrl[CTRL_EN] || w_tick) ? '0 : r_presc + DIV_W'(1);
    assign w_value_nxt   = w_wr_value ? r_reload :
                           !w_tick ? r_value :
                           !w_zero ? r_value - CNT_W'(1) :
                           r_ctrl[CTRL_AUTO] ? r_reload : r_value;
    assign w_expired_nxt = w_wr_value ? 1'b0 : (w_tick & w_zero & ~r_ctrl[CTRL_AUTO]) | r_expired;
    assign w_flag_nxt    = w_set | (r_flag & ~w_wr_value & ~(w_wr_status & HWDATA[0]));
    assign w_pend_w1c    = {NUM_IRQ{w_wr_pend}} & HWDATA[NUM_IRQ-1:0];

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq
        el2_irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
            .i_clk      (HCLK),
            .i_rst      (HRESET),
            .i_irq      (IRQ[i]),
            .i_edge     (r_mode[i]),
            .i_w1c      (w_pend_w1c[i]),
            .o_pend     (w_pend[i]),
            .o_pend_nxt (w_pend_nxt[i])
        );
    end

    // Reads sample post-commit values so a write followed by a read is forwarded
    always_comb begin
        w_rdata = '0;
        case (HADDR[4:2])
            A_CTRL:   w_rdata[2:0] = w_ctrl_nxt;
            A_RELOAD: w_rdata[CNT_W-1:0] = w_reload_nxt;
            A_VALUE:  w_rdata[CNT_W-1:0] = w_value_nxt;
            A_STATUS: w_rdata[0] = w_flag_nxt;
            A_MODE:   w_rdata[NUM_IRQ-1:0] = w_mode_nxt;
            A_PEND:   w_rdata[NUM_IRQ-1:0] = w_pend_nxt;
            A_MASK:   w_rdata[NUM_IRQ-1:0] = w_mask_nxt;
            default:  w_rdata = '0;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_wr          <= 1'b0;
            r_addr        <= '0;
            r_ctrl        <= '0;
            r_reload      <= '0;
            r_value       <= '0;
            r_presc       <= '0;
            r_flag        <= 1'b0;
            r_expired     <= 1'b0;
            r_mode        <= '0;
            r_mask        <= '0;
            HRDATA        <= '0;
            timer_int     <= 1'b0;
            extintsrc_req <= '0;
        end else begin
            r_wr          <= w_sel & HWRITE;
            r_addr        <= HADDR[4:2];
            r_ctrl        <= w_ctrl_nxt;
            r_reload      <= w_reload_nxt;
            r_value       <= w_value_nxt;
            r_presc       <= w_presc_nxt;
            r_flag        <= w_flag_nxt;
            r_expired     <= w_expired_nxt;
            r_mode        <= w_mode_nxt;
            r_mask        <= w_mask_nxt;
            HRDATA        <= (w_sel & ~HWRITE) ? w_rdata : '0;
            timer_int     <= r_flag & r_ctrl[CTRL_TICKINT];
            extintsrc_req <= w_pend & r_mask;
        end
    end
endmodule
